// File: rtl/thiele_prog_loader.sv
// ---------------------------------------------------------------------------
// thiele_prog_loader
//
// Boot/load sequencer for the Kami-generated Thiele CPU core (mkModule1).
// One start pulse runs the whole bring-up flow:
//   LOAD : stream prog_len words from a valid/ready source into the core's
//          instruction memory through its loadInstr method.
//   PAD  : fill every remaining imem slot with PAD_WORD (a HALT), so stale
//          words from an earlier, longer program can never execute.
//   CRST : hold the core in reset for RST_CYC cycles. The core reset clears
//          pc/mu/regs/mem/counters but leaves imem intact.
//   RUN  : release the core and watch getHalted/getErr under a watchdog.
//   DONE : status and cycle count hold until the next start.
// The same sequencer serves both board bring-up and simulation, so no
// force/release of core internals is needed.
//
// Optional feature (compile-time macro THIELE_LOADER_CHECKSUM_EN):
//   Adds exp_sum (sampled at start) and load_sum. load_sum is the
//   mod-2**DATA_W sum of the accepted source words; padding is excluded.
//   When the image is complete and load_sum != exp_sum, the sequence ends
//   in DONE with status 4 and the core is never reset or run.
//   With the macro undefined, these ports do not exist and status 4 never
//   occurs.
//
// Parameters
//   ADDR_W     instruction address width
//   DATA_W     instruction word width
//   DEPTH      number of imem slots (<= 2**ADDR_W)
//   PAD_WORD   word written to slots at or above the program length
//   RST_CYC    core reset pulse length in cycles (>= 1)
//   MAX_CYCLES watchdog limit for the RUN phase
//
// Ports
//   CLK         clock
//   RST_N       synchronous active-low reset
//   start       pulse; begins a load+run sequence (only in IDLE/DONE)
//   prog_len    number of source words to load, sampled at start
//   src_valid   source word valid
//   src_data    source word
//   src_ready   loader accepts the source word this cycle
//   load_x      {addr, word} to the core's loadInstr_x_0
//   load_en     to the core's EN_loadInstr
//   load_rdy    from the core's RDY_loadInstr
//   core_rst_n  core reset, active low
//   cpu_halted  core getHalted
//   cpu_err     core getErr
//   exp_sum     expected program checksum (checksum build only)
//   load_sum    running checksum of accepted words (checksum build only)
//   busy        a sequence is in progress (state is not IDLE or DONE)
//   done        sequence finished; status is valid
//   status      0 none, 1 timeout, 2 halted, 3 err, 4 checksum fail
//   cycles      RUN cycles elapsed; saturates, never wraps
// ---------------------------------------------------------------------------
module thiele_prog_loader #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 256,
    parameter logic [DATA_W-1:0] PAD_WORD   = 32'hFF000000,
    parameter int                RST_CYC    = 2,
    parameter int                MAX_CYCLES = 10000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic [ADDR_W:0]          prog_len,
    input  logic                     src_valid,
    input  logic [DATA_W-1:0]        src_data,
    output logic                     src_ready,
    output logic [ADDR_W+DATA_W-1:0] load_x,
    output logic                     load_en,
    input  logic                     load_rdy,
    output logic                     core_rst_n,
    input  logic                     cpu_halted,
    input  logic                     cpu_err,
`ifdef THIELE_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0]        exp_sum,
    output logic [DATA_W-1:0]        load_sum,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               status,
    output logic [31:0]              cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_CRST,
        S_RUN,
        S_DONE
    } state_t;

    // addr/len carry one extra bit so that DEPTH == 2**ADDR_W is
    // representable and the PAD loop can terminate without wrapping.
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);
    localparam logic [31:0]     RST_LAST = 32'(RST_CYC - 1);
    localparam logic [31:0]     CYC_LAST = 32'(MAX_CYCLES - 1);

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_TIMEOUT = 3'd1;
    localparam logic [2:0] ST_HALTED  = 3'd2;
    localparam logic [2:0] ST_ERR     = 3'd3;
`ifdef THIELE_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CKSUM   = 3'd4;
`endif

    state_t                   state_q, state_d;
    logic [ADDR_W:0]          addr_q, addr_d;
    logic [ADDR_W:0]          len_q, len_d;
    logic [31:0]              rst_cnt_q, rst_cnt_d;
    logic [31:0]              cycles_q, cycles_d;
    logic [2:0]               status_q, status_d;
    logic                     done_q, done_d;
    logic                     core_rst_n_q, core_rst_n_d;
`ifdef THIELE_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]        sum_q, sum_d;
    logic [DATA_W-1:0]        exp_q, exp_d;
`endif

    // Unqualified handshake values; gated by RST_N below.
    logic                     src_ready_c;
    logic                     load_en_c;
    logic [ADDR_W+DATA_W-1:0] load_x_c;
    // Asserted in the cycle the last imem slot is written.
    logic                     image_done;

    // State register and all sequencer flops. Reset is synchronous; a
    // reset in the middle of a load simply abandons it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            rst_cnt_q    <= '0;
            cycles_q     <= '0;
            status_q     <= ST_NONE;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef THIELE_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            exp_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rst_cnt_q    <= rst_cnt_d;
            cycles_q     <= cycles_d;
            status_q     <= status_d;
            done_q       <= done_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef THIELE_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            exp_q        <= exp_d;
`endif
        end
    end

    // Next-state and datapath logic for the whole load/pad/reset/run flow.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rst_cnt_d   = rst_cnt_q;
        cycles_d    = cycles_q;
        status_d    = status_q;
        done_d      = done_q;
        src_ready_c = 1'b0;
        load_en_c   = 1'b0;
        load_x_c    = '0;
        image_done  = 1'b0;
`ifdef THIELE_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        exp_d       = exp_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d    = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;
                    addr_d   = '0;
                    cycles_d = '0;
                    status_d = ST_NONE;
                    done_d   = 1'b0;
`ifdef THIELE_LOADER_CHECKSUM_EN
                    sum_d    = '0;
                    exp_d    = exp_sum;
`endif
                    // An empty program never offers src_ready.
                    state_d  = (len_d == '0) ? S_PAD : S_LOAD;
                end
            end

            S_LOAD: begin
                src_ready_c = load_rdy;
                load_x_c    = {addr_q[ADDR_W-1:0], src_data};
                if (src_valid && load_rdy) begin
                    load_en_c = 1'b1;
                    addr_d    = addr_q + ADDR_ONE;
`ifdef THIELE_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + src_data;
`endif
                    // A full-depth program has nothing to pad, so skip
                    // PAD entirely rather than spending a cycle there.
                    if (addr_d == len_q) begin
                        if (addr_d == DEPTH_V) begin
                            image_done = 1'b1;
                        end else begin
                            state_d = S_PAD;
                        end
                    end
                end
            end

            S_PAD: begin
                load_en_c = load_rdy;
                load_x_c  = {addr_q[ADDR_W-1:0], PAD_WORD};
                if (load_rdy) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (addr_d == DEPTH_V) begin
                        image_done = 1'b1;
                    end
                end
            end

            S_CRST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end

            S_RUN: begin
                // The exit cycle counts too, so a timeout reports exactly
                // MAX_CYCLES.
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (cpu_halted) begin
                    status_d = ST_HALTED;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (cpu_err) begin
                    status_d = ST_ERR;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (cycles_q == CYC_LAST) begin
                    status_d = ST_TIMEOUT;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Image complete: either hand the core its reset pulse or, on a
        // checksum mismatch, stop without ever touching the core.
        if (image_done) begin
`ifdef THIELE_LOADER_CHECKSUM_EN
            if (sum_d != exp_q) begin
                status_d = ST_CKSUM;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end else begin
                rst_cnt_d = '0;
                state_d   = S_CRST;
            end
`else
            rst_cnt_d = '0;
            state_d   = S_CRST;
`endif
        end
    end

    // core_rst_n is registered off the next state, so it is low for
    // exactly the cycles spent in CRST and rises on the first cycle after
    // RST_N is released.
    always_comb begin
        core_rst_n_d = (state_d != S_CRST);
    end

    // Handshake outputs are forced quiet while RST_N is low so that no
    // transfer can slip through in the cycle a reset is requested.
    assign src_ready  = RST_N & src_ready_c;
    assign load_en    = RST_N & load_en_c;
    assign load_x     = RST_N ? load_x_c : '0;
    assign core_rst_n = core_rst_n_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = done_q;
    assign status     = status_q;
    assign cycles     = cycles_q;
`ifdef THIELE_LOADER_CHECKSUM_EN
    assign load_sum   = sum_q;
`endif

endmodule
